// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: WIDTH-cycle shift-add multiply or
// restoring divide on operand magnitudes, followed by one sign-correction cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_hilo,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 is_div_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic [WIDTH-1:0]     a_raw_reg;
    logic [WIDTH-1:0]     mag_b_reg;
    logic [2*WIDTH-1:0]   work_reg;

    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       sub_diff;
    logic [2*WIDTH-1:0]   step_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    // op[0]=0 selects the signed variants (MULT/DIV)
    always_comb begin
        sign_a = ~op[0] & a[WIDTH-1];
        sign_b = ~op[0] & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // work_reg holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        add_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, mag_b_reg} : '0);
        rem_sh   = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
        sub_diff = rem_sh - {1'b0, mag_b_reg};
        if (!is_div_reg) begin
            step_next = {add_sum, work_reg[WIDTH-1:1]};
        end else if (sub_diff[WIDTH]) begin
            step_next = {rem_sh[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
        end else begin
            step_next = {sub_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        prod_fix = neg_q_reg ? -work_reg : work_reg;
        quot_fix = neg_q_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
        rem_fix  = neg_r_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            // divide by zero reports the raw dividend and an all-ones quotient
            if (mag_b_reg == '0) begin
                res_hi = a_raw_reg;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            a_raw_reg  <= '0;
            mag_b_reg  <= '0;
            work_reg   <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (we_hi) hi <= wdata;
                    if (we_lo) lo <= wdata;
                    if (start && !flush) begin
                        is_div_reg <= op[1];
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
                        a_raw_reg  <= a;
                        mag_b_reg  <= mag_b;
                        work_reg   <= {{WIDTH{1'b0}}, mag_a};
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        work_reg <= step_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST) state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign stall = busy & (start | read_hilo | we_hi | we_lo);

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: directed vectors at WIDTH=32 plus a WIDTH=8
// instance checked against a signed/unsigned arithmetic reference.
module tb_mips_muldiv;

    localparam int W = 32;
    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, read_hilo, we_hi, we_lo, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata, hi, lo;
    logic         busy, done, stall;

    logic         start8;
    logic [1:0]   op8;
    logic [7:0]   a8, b8, hi8, lo8;
    logic         busy8, done8, stall8;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .read_hilo(read_hilo), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .read_hilo(1'b0), .we_hi(1'b0), .we_lo(1'b0), .wdata(8'h00),
        .flush(1'b0), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .stall(stall8)
    );

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp8_q[$];
    exp_t        mon_e;
    logic [15:0] mon_e8;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitors: pop an expected result whenever a unit reports done
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn32 hi=%h lo=%h (expect %h %h)", hi, lo, mon_e.h, mon_e.l);
                check("hi32", 64'(hi), 64'(mon_e.h));
                check("lo32", 64'(lo), 64'(mon_e.l));
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8: got hi=%h lo=%h, expected no done", hi8, lo8);
            end else begin
                mon_e8 = exp8_q.pop_front();
                $display("txn8 hi=%h lo=%h (expect %h)", hi8, lo8, mon_e8);
                check("hilo8", 64'({hi8, lo8}), 64'(mon_e8));
            end
        end
    end

    function automatic logic [15:0] ref8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        longint sx, sy, ux, uy, p, q, m;
        logic [15:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({56'd0, x});
        uy = longint'({56'd0, y});
        r  = 16'h0;
        case (o)
            MULT:  begin p = sx * sy; r = p[15:0]; end
            MULTU: begin p = ux * uy; r = p[15:0]; end
            DIV: begin
                if (y == 8'h00) r = {x, 8'hFF};
                else begin q = sx / sy; m = sx % sy; r = {m[7:0], q[7:0]}; end
            end
            default: begin
                if (y == 8'h00) r = {x, 8'hFF};
                else begin q = ux / uy; m = ux % uy; r = {m[7:0], q[7:0]}; end
            end
        endcase
        return r;
    endfunction

    // Drives start for one edge; returns at the falling edge of cycle 1
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic push, input logic [W-1:0] eh, input logic [W-1:0] el);
        start = 1'b1; op = o; a = x; b = y;
        if (push) exp_q.push_back({eh, el});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        launch(o, x, y, 1'b1, eh, el);
        wait_done();
    endtask

    task automatic lat_check(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] eh, input logic [W-1:0] el);
        launch(o, x, y, 1'b1, eh, el);
        for (int c = 1; c <= W + 2; c++) begin
            if (c <= W + 1) begin
                check("busy_in_flight", 64'(busy), 64'(1));
                check("no_early_done", 64'(done), 64'(0));
            end else begin
                check("done_at_w_plus_2", 64'(done), 64'(1));
                check("busy_after", 64'(busy), 64'(0));
            end
            if (c < W + 2) @(negedge clk);
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        exp8_q.push_back(ref8(o, x, y));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        while (done8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done8_timeout", 64'(done8), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b1; read_hilo = 1'b1; we_hi = 1'b0; we_lo = 1'b0; flush = 1'b0;
        op = MULT; a = '0; b = '0; wdata = '0;
        start8 = 1'b0; op8 = MULT; a8 = '0; b8 = '0;
        #2;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        start = 1'b0; read_hilo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        lat_check(MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        run_op(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op(DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3);
        run_op(DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
        run_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op(DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF);
        run_op(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1);

        // MTHI/MTLO while idle
        we_hi = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        we_hi = 1'b0;
        check("mthi", 64'(hi), 64'h12345678);
        we_lo = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clk);
        we_lo = 1'b0;
        check("mtlo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo_keeps_hi", 64'(hi), 64'h12345678);

        // Stall from MFHI/MFLO and ignored MTHI while busy
        launch(MULT, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30);
        for (int c = 1; c <= W + 2; c++) begin
            read_hilo = (c >= 5);
            we_hi = (c == 10);
            wdata = 32'hFFFF0000;
            #1;
            if (c == 4 || c == 5 || c == 10 || c == W + 1 || c == W + 2)
                check($sformatf("stall_c%0d", c), 64'(stall), 64'((c >= 5 && c <= W + 1) ? 1 : 0));
            if (c == 11) check("hi_kept_busy_write", 64'(hi), 64'h12345678);
            if (c < W + 2) @(negedge clk);
        end
        read_hilo = 1'b0; we_hi = 1'b0;
        @(negedge clk);

        // start while busy is ignored
        launch(MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
        repeat (5) @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd5;
        #1;
        check("stall_on_busy_start", 64'(stall), 64'(1));
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        check("idle_after_ignored_start", 64'(busy), 64'(0));

        // MTHI with start in the same idle cycle
        we_hi = 1'b1; wdata = 32'hAAAA5555;
        launch(MULT, 32'd2, 32'd2, 1'b1, 32'd0, 32'd4);
        we_hi = 1'b0;
        check("mthi_with_start", 64'(hi), 64'hAAAA5555);
        check("busy_with_mthi", 64'(busy), 64'(1));
        wait_done();
        @(negedge clk);

        // flush during RUN
        launch(DIV, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_busy", 64'(busy), 64'(0));
        check("flush_run_hilo", 64'({hi, lo}), {32'd0, 32'd4});
        repeat (40) @(negedge clk);

        // flush during FIX
        launch(MULT, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
        repeat (W) @(negedge clk);
        check("fix_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fix_busy", 64'(busy), 64'(0));
        check("flush_fix_hilo", 64'({hi, lo}), {32'd0, 32'd4});
        repeat (4) @(negedge clk);

        // start with flush in idle is discarded; MTLO with flush still applies
        start = 1'b1; flush = 1'b1; we_lo = 1'b1; wdata = 32'h77; op = MULT; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; we_lo = 1'b0;
        check("start_flush_idle", 64'(busy), 64'(0));
        check("mtlo_with_flush", 64'(lo), 64'h77);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-operation
        launch(MULT, 32'd7, 32'd7, 1'b0, 32'd0, 32'd0);
        repeat (19) @(negedge clk);
        read_hilo = 1'b1;
        #1;
        check("stall_before_rst", 64'(stall), 64'(1));
        rst = 1'b1;
        #1;
        check("async_rst_hilo", 64'({hi, lo}), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst = 1'b0; read_hilo = 1'b0;
        @(negedge clk);
        lat_check(MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // WIDTH=8 directed and random reference compares
        run8(MULT,  8'hFE, 8'h03);
        run8(DIV,   8'hF9, 8'h02);
        run8(DIVU,  8'h07, 8'h00);
        run8(DIV,   8'h80, 8'hFF);
        run8(MULTU, 8'hFF, 8'hFF);
        run8(MULT,  8'h80, 8'h80);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = (i % 9 == 0) ? 8'h00 : 8'($urandom);
            run8(ro, ra, rb);
        end

        repeat (5) @(negedge clk);
        check("queue32_empty", 64'(exp_q.size()), 64'(0));
        check("queue8_empty", 64'(exp8_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; legal values are 8 to 64, even.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, meaning decode issues MULT/MULTU/DIV/DIVU this cycle.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, WIDTH bits, meaning rs operand (multiplicand/dividend).
REQ-007 SHALL have port b, input, WIDTH bits, meaning rt operand (multiplier/divisor).
REQ-008 SHALL have port read_hilo, input, 1 bit, meaning decode holds MFHI/MFLO this cycle.
REQ-009 SHALL have ports we_hi and we_lo, input, 1 bit each, meaning MTHI/MTLO write.
REQ-010 SHALL have port wdata, input, WIDTH bits, meaning MTHI/MTLO data.
REQ-011 SHALL have port flush, input, 1 bit, meaning abandon the in-flight operation.
REQ-012 SHALL have ports hi and lo, output, WIDTH bits each, meaning the architectural HI/LO registers.
REQ-013 SHALL have port busy, output, 1 bit, meaning an operation is in flight.
REQ-014 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when hi/lo were just updated by an operation.
REQ-015 SHALL have port stall, output, 1 bit, meaning decode must hold.

Function
REQ-016 SHALL implement states IDLE, RUN and FIX; busy=1 exactly in RUN and FIX.
REQ-017 In IDLE with start=1, SHALL latch op, a and b, then enter RUN on the next edge.
REQ-018 SHALL stay in RUN for exactly WIDTH cycles, one shift-add or restoring-subtract step per cycle, on operand magnitudes.
REQ-019 FIX SHALL last 1 cycle for sign correction; at its ending edge SHALL write hi/lo, return to IDLE, and drive done=1 for the following cycle only.
REQ-020 Fixed latency: start sampled at edge 0 means hi/lo are valid and done=1 in cycle WIDTH+2; busy=1 in cycles 1..WIDTH+1.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the 2*WIDTH-bit signed or unsigned product respectively.
REQ-022 DIV: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder, carrying the sign of the dividend.
REQ-023 DIVU: lo SHALL be the unsigned quotient and hi the unsigned remainder.
REQ-024 Divide by zero (DIV or DIVU) SHALL run the normal latency, then write lo=all-ones and hi=a; no exception is raised.
REQ-025 DIV of most-negative by -1 SHALL write lo=most-negative, hi=0.
REQ-026 stall SHALL equal busy & (start | read_hilo | we_hi | we_lo), combinationally.
REQ-027 start while busy SHALL be ignored; the in-flight operation is unaffected.
REQ-028 we_hi/we_lo in IDLE SHALL update hi/lo from wdata at the next edge; ignored while busy.
REQ-029 start and we_hi/we_lo together in IDLE SHALL apply the write now and launch the operation; the result overwrites hi/lo later.
REQ-030 flush in RUN or FIX SHALL return to IDLE at the next edge, leave hi/lo unchanged, and suppress done; flush in IDLE SHALL have no effect.
REQ-031 flush has priority over start in the same cycle when busy; in IDLE, start with flush SHALL be discarded.
REQ-032 A new start SHALL be accepted in the cycle done=1 (back-to-back issue).

Reset
REQ-033 rst=1 SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, stall=0, independent of clk.
REQ-034 rst asserted mid-operation SHALL discard the operation; the first start after deassertion behaves per REQ-020.

Verification
REQ-035 WIDTH=32, MULT a=0xFFFFFFFE (-2), b=3 -> cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1; busy=1 in cycles 1..33.
REQ-036 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 start MULT, then read_hilo=1 in cycle 5 -> stall=1 until cycle 33; we_hi=1 in cycle 10 -> stall=1 and hi unchanged.
REQ-039 start DIV, flush in cycle 12 -> busy=0 in cycle 13, done never pulses, hi/lo keep their prior values; rst in cycle 20 of a second op -> hi=lo=0 at once.
REQ-040 Repeat the REQ-035 to REQ-037 checks at WIDTH=8 and WIDTH=16 with a randomized signed/unsigned reference compare.
